pipelined_multiplier: RTL and testbench
=======================================

// Module: pipelined_multiplier
// PURPOSE
//  Fully pipelined shift-add multiplier: signed multiplicand x unsigned multiplier, one multiplier bit per stage.
//  Inverse-operation companion to the pipelined divider in the sobel_v2 datapath (rescales normalised results).
//  Same valid/6-bit-tag sideband: tags travel with data, so a consumer can match results to requests.
//  Accepts one operation per clock, no backpressure.
// PARAMETERS
//  multiplicand_width  12  width of signed multiplicand (two's complement)
//  multiplier_width     6  width of unsigned multiplier; equals the number of add stages
//  stages              multiplier_width  derived; do not override
//  product_width       multiplicand_width+multiplier_width  derived; full-precision signed product width
//  sat_width           12  signed clamp width, used only when PIPE_MULT_SAT_EN is defined (<= product_width)
// PORTS
//  clock         in   1                   rising-edge clock
//  reset_n       in   1                   synchronous active-low reset
//  input_valid   in   1                   operands valid this cycle
//  input_tag     in   6                   request tag, returned unchanged with the result
//  multiplicand  in   multiplicand_width  signed operand
//  multiplier    in   multiplier_width    unsigned operand
//  output_valid  out  1                   product/tag valid this cycle
//  output_tag    out  6                   tag of the current result
//  product       out  product_width       signed product (sign-extended clamp if PIPE_MULT_SAT_EN)
//  overflow      out  1                   clamp applied to this result (constant 0 without PIPE_MULT_SAT_EN)
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): every stage_valid, output_valid, output_tag, product and overflow clear to 0 on that edge.
//   Data/tag registers inside the pipeline need not reset. Reset mid-operation discards all in-flight ops.
//   No output_valid is asserted until a new input is accepted after reset_n returns high.
//  Stage 0 (input register):
//   - neg_flag = multiplicand MSB.
//   - mag = |multiplicand|, held as an unsigned multiplicand_width value, so -2^(mw-1) maps to 2^(mw-1).
//   - partial = 0; multiplier, valid and tag captured.
//  Stage i+1, i=0..stages-1: if multiplier[i], partial += mag<<i, else partial unchanged.
//   - partial is unsigned, product_width-1 bits wide; it cannot overflow.
//   - mag, multiplier, neg_flag, valid and tag are forwarded unchanged.
//  Output register: product = neg_flag ? -partial : partial, sign-extended to product_width.
//   A negative multiplicand times 0 yields 0, never -0 artefacts.
//  Latency: exactly stages+2 clocks from the input_valid sample to output_valid (8 at defaults).
//   Throughput 1 op/clock.
//  input_valid=0 bubbles propagate as output_valid=0 in the matching slot.
//   Data is don't-care for invalid slots, but output_tag still follows the pipeline.
//  Operands are sampled every clock regardless of input_valid; valid only qualifies the result.
// CONFIGURATION
//  PIPE_MULT_SAT_EN defined: output stage clamps the signed product to [-2^(sat_width-1), 2^(sat_width-1)-1].
//   - The clamped value is sign-extended onto product.
//   - overflow=1 in the same cycle as output_valid when the clamp was applied, else 0.
//   - Latency is unchanged.
//  PIPE_MULT_SAT_EN undefined: full-precision product, overflow tied to 0, no clamp logic synthesised.
// TESTING
//  1 Reset: hold reset_n=0 4 clocks with input_valid=1 -> output_valid=0, product=0, tag=0 throughout and 7 clocks after release with input_valid=0.
//  2 Latency/basic: at t0, 100 x 30 tag 5 -> output at t0+8: product=3000, tag=5, output_valid=1 (no SAT_EN).
//  3 Signs/corners: -2048x63 -> -129024; 2047x63 -> 128961; -7x0 -> 0; 0x63 -> 0; -1x1 -> -1.
//  4 Back-to-back: 9 consecutive ops with distinct tags and one bubble -> results in order, one per clock, bubble slot output_valid=0.
//  5 Mid-flight reset: issue 4 ops, reset_n=0 for 1 clock at t0+3 -> none of the 4 ever appear; a new op afterwards arrives 8 clocks after issue.
//  6 SAT_EN build: 100x30 -> 2047, overflow=1; -2048x2 -> -2048, overflow=1; -2048x1 -> -2048, overflow=0.
//  Exhaustive sweep (4096x64) vs. behavioural a*b with tag-indexed scoreboard, in both builds.

Source files
------------

// File: rtl/pipelined_multiplier.sv
// Pipelined shift-add multiplier: signed multiplicand x unsigned multiplier, one multiplier bit per stage.
// Define PIPE_MULT_SAT_EN to clamp the product to sat_width bits and report clamps on overflow.
`timescale 1ns/1ps
module pipelined_multiplier #(
  parameter int multiplicand_width = 12,
  parameter int multiplier_width = 6,
  localparam int stages = multiplier_width,
  localparam int product_width = multiplicand_width + multiplier_width,
  parameter int sat_width = 12
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 input_valid,
  input  logic [5:0]                           input_tag,
  input  logic signed [multiplicand_width-1:0] multiplicand,
  input  logic [multiplier_width-1:0]          multiplier,
  output logic                                 output_valid,
  output logic [5:0]                           output_tag,
  output logic signed [product_width-1:0]      product,
  output logic                                 overflow
);

  localparam int part_width = product_width - 1;

  if (sat_width < 2 || sat_width > product_width) begin : g_bad_sat_width
    $error("sat_width must lie in [2, product_width]");
  end

  logic                          vld_p     [0:stages];
  logic [5:0]                    tag_p     [0:stages];
  logic                          neg_p     [0:stages];
  logic [part_width-1:0]         partial_p [0:stages];
  logic [multiplicand_width-1:0] mag_p     [0:stages-1];
  logic [multiplier_width-1:0]   mplr_p    [0:stages-1];

  logic signed [product_width-1:0] full_prod;
  logic signed [product_width-1:0] sat_prod;
  logic                            sat_hit;

  // Unsigned magnitude: the most negative input maps onto 2^(w-1), which still fits.
  function automatic logic [multiplicand_width-1:0] magnitude(
    input logic signed [multiplicand_width-1:0] v);
    return v[multiplicand_width-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [product_width-1:0] apply_sign(
    input logic neg, input logic [part_width-1:0] mag);
    logic signed [product_width-1:0] mag_s;
    mag_s = $signed({1'b0, mag});
    return neg ? -mag_s : mag_s;
  endfunction

`ifdef PIPE_MULT_SAT_EN
  localparam logic signed [product_width-1:0] sat_max =
    product_width'((64'sd1 <<< (sat_width - 1)) - 64'sd1);
  localparam logic signed [product_width-1:0] sat_min = ~sat_max;

  function automatic logic signed [product_width-1:0] sat_clamp(
    input logic signed [product_width-1:0] v);
    if (v > sat_max) return sat_max;
    if (v < sat_min) return sat_min;
    return v;
  endfunction

  function automatic logic sat_detect(input logic signed [product_width-1:0] v);
    return (v > sat_max) || (v < sat_min);
  endfunction
`endif

  // Stage 0 and add stages: valid chain (reset-controlled)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i <= stages; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= input_valid;
      for (int i = 0; i < stages; i++) vld_p[i+1] <= vld_p[i];
    end
  end

  // Stage 0 capture, then stage i+1 adds mag<<i when multiplier bit i is set
  always_ff @(posedge clock) begin
    neg_p[0]     <= multiplicand[multiplicand_width-1];
    mag_p[0]     <= magnitude(multiplicand);
    mplr_p[0]    <= multiplier;
    tag_p[0]     <= input_tag;
    partial_p[0] <= '0;
    for (int i = 0; i < stages; i++) begin
      neg_p[i+1]     <= neg_p[i];
      tag_p[i+1]     <= tag_p[i];
      partial_p[i+1] <= mplr_p[i][i] ? partial_p[i] + (part_width'(mag_p[i]) << i)
                                     : partial_p[i];
    end
    for (int i = 0; i < stages - 1; i++) begin
      mag_p[i+1]  <= mag_p[i];
      mplr_p[i+1] <= mplr_p[i];
    end
  end

  always_comb begin
    full_prod = apply_sign(neg_p[stages], partial_p[stages]);
`ifdef PIPE_MULT_SAT_EN
    sat_prod  = sat_clamp(full_prod);
    sat_hit   = sat_detect(full_prod);
`else
    sat_prod  = full_prod;
    sat_hit   = 1'b0;
`endif
  end

  // Output register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      output_valid <= 1'b0;
      output_tag   <= '0;
      product      <= '0;
      overflow     <= 1'b0;
    end else begin
      output_valid <= vld_p[stages];
      output_tag   <= tag_p[stages];
      product      <= sat_prod;
      overflow     <= sat_hit;
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Randomised and directed bench for pipelined_multiplier against a cycle-history reference model.
`timescale 1ns/1ps
module tb_pipelined_multiplier;
  localparam int MW  = 12;
  localparam int NW  = 6;
  localparam int PW  = MW + NW;
  localparam int SW  = 12;
  localparam int LAT = NW + 2;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 input_valid;
  logic [5:0]           input_tag;
  logic signed [MW-1:0] multiplicand;
  logic [NW-1:0]        multiplier;
  logic                 output_valid;
  logic [5:0]           output_tag;
  logic signed [PW-1:0] product;
  logic                 overflow;

  pipelined_multiplier dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_valid  (input_valid),
    .input_tag    (input_tag),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .output_valid (output_valid),
    .output_tag   (output_tag),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         v;
    logic [5:0] tag;
    int         a;
    int         b;
  } slot_t;

  slot_t hist [16];
  int    cyc      = 0;
  int    last_rst = -100;
  int    checks   = 0;
  int    failures = 0;
  bit    phase1   = 1'b0;

  function automatic longint ref_prod(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
`ifdef PIPE_MULT_SAT_EN
    if (p > (64'sd1 <<< (SW - 1)) - 1) p = (64'sd1 <<< (SW - 1)) - 1;
    else if (p < -(64'sd1 <<< (SW - 1))) p = -(64'sd1 <<< (SW - 1));
`endif
    return p;
  endfunction

  function automatic longint ref_ovf(int a, int b);
`ifdef PIPE_MULT_SAT_EN
    longint p;
    p = longint'(a) * longint'(b);
    return ((p > (64'sd1 <<< (SW - 1)) - 1) || (p < -(64'sd1 <<< (SW - 1)))) ? 1 : 0;
`else
    return (a * b * 0);
`endif
  endfunction

  task automatic check(string name, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, record, then compare the output register after the edge.
  task automatic step(bit rn, bit v, logic [5:0] t, int a, int b);
    slot_t s;
    bit    killed;
    bit    exp_v;
    @(negedge clock);
    reset_n      = rn;
    input_valid  = v;
    input_tag    = t;
    multiplicand = MW'(a);
    multiplier   = NW'(b);
    hist[cyc % 16] = '{rst: !rn, v: v, tag: t, a: a, b: b};
    @(posedge clock);
    #1;
    if (!rn) begin
      last_rst = cyc;
      check("rst_valid", output_valid, 0);
      check("rst_tag", output_tag, 0);
      check("rst_product", product, 0);
      check("rst_overflow", overflow, 0);
    end else if (cyc >= LAT - 1) begin
      s      = hist[(cyc - (LAT - 1)) % 16];
      killed = (last_rst >= cyc - (LAT - 1));
      exp_v  = !killed && s.v;
      check("valid", output_valid, exp_v);
      if (!killed || phase1) check("tag", output_tag, s.tag);
      if (exp_v || phase1) check("product", $signed(product), ref_prod(s.a, s.b));
`ifdef PIPE_MULT_SAT_EN
      if (exp_v) check("overflow", overflow, ref_ovf(s.a, s.b));
`else
      check("overflow", overflow, ref_ovf(s.a, s.b));
`endif
    end
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 6'(cyc), 0, 0);
  endtask

  int corner_a [9] = '{-2048, 2047, -7, 0, -1, 100, -2048, -2048, 1234};
  int corner_b [9] = '{63, 63, 0, 63, 1, 30, 2, 1, 45};
  int edge_a   [4] = '{-2048, 2047, 0, -1};

  initial begin
    int a;
    int b;
    reset_n      = 1'b0;
    input_valid  = 1'b1;
    input_tag    = '0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset held with valid inputs, then quiet release window
    phase1 = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 6'd0, 0, 0);
    for (int i = 0; i < LAT - 1; i++) step(1'b1, 1'b0, 6'd0, 0, 0);
    phase1 = 1'b0;

    // Single operation latency
    step(1'b1, 1'b1, 6'd5, 100, 30);
    idle(LAT);

    // Corners back-to-back with one bubble
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 6'(10 + i), corner_a[i], corner_b[i]);
      if (i == 4) step(1'b1, 1'b0, 6'd33, 55, 7);
    end
    idle(LAT);

    // Mid-flight reset discards in-flight ops
    step(1'b1, 1'b1, 6'd40, 300, 17);
    step(1'b1, 1'b1, 6'd41, -300, 17);
    step(1'b1, 1'b1, 6'd42, 5, 5);
    step(1'b0, 1'b1, 6'd43, 9, 9);
    idle(2);
    step(1'b1, 1'b1, 6'd50, -123, 45);
    idle(LAT + 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 7) == 0) a = edge_a[$urandom_range(0, 3)];
      b = int'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 0 : 63;
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0), 6'(cyc), a, b);
    end
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
